icache_dm: RTL and testbench

- Parametrised direct-mapped, read-only instruction cache.
- Replaces the per-CPU pass-through instruction path between the datapath fetch port and the memory controller's instruction channel.
- Hits return in the same cycle. Misses fill a whole multi-word block from memory using the iREN/iwait handshake, then the access completes as a hit.

---
 rtl/icache_dm_if.sv | 23 ++
 rtl/icache_dm.sv | 150 +++++++++++++++
 tb/tb_icache_dm.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signal bundle of the direct-mapped instruction cache.
// The cache takes the slave modport; the datapath/memory model side takes the master modport.
interface icache_dm_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-block fill on miss.
// Optional ICACHE_STATS_EN adds hitcnt/misscnt counter ports.
module icache_dm #(
    parameter int unsigned NSETS    = 16,
    parameter int unsigned BLKWORDS = 2,
    parameter int unsigned CPUID    = 0
) (
    input  logic          CLK,
    input  logic          nRST,
    icache_dm_if.slave    bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   hitcnt,
    output logic [31:0]   misscnt
`endif
);

    localparam int unsigned OB    = $clog2(BLKWORDS);
    localparam int unsigned IB    = $clog2(NSETS);
    localparam int unsigned TW    = 30 - OB - IB;
    localparam int unsigned OBW   = (OB > 0) ? OB : 1;
    localparam int unsigned DEPTH = NSETS * BLKWORDS;
    localparam int unsigned DAW   = $clog2(DEPTH);

    if (NSETS < 2 || (NSETS & (NSETS - 1)) != 0 ||
        BLKWORDS < 1 || (BLKWORDS & (BLKWORDS - 1)) != 0) begin : g_param_check
        $error("icache_dm%0d: NSETS and BLKWORDS must be powers of two", CPUID);
    end

    typedef enum logic {IDLE, FILL} state_e;

    state_e            state_q;
    logic [OBW-1:0]    cnt_q;
    logic [TW-1:0]     miss_tag_q;
    logic [IB-1:0]     miss_idx_q;
    logic [NSETS-1:0]  valid_q;
    logic [TW-1:0]     tag_arr_q  [NSETS];
    logic [31:0]       data_arr_q [DEPTH];

    logic [31:0]       addr_c;
    logic [29:0]       waddr_c;
    logic [OBW-1:0]    req_off_c;
    logic [IB-1:0]     req_idx_c;
    logic [TW-1:0]     req_tag_c;
    logic              hit_c;
    logic              start_miss_c;
    logic              last_c;
    logic              fill_we_c;
    logic [DAW-1:0]    rd_addr_c;
    logic [DAW-1:0]    wr_addr_c;

    // Address split into block offset, set index and tag
    always_comb begin
        addr_c    = bus.imemaddr;
        waddr_c   = 30'(addr_c >> 2);
        req_off_c = OBW'(waddr_c & 30'(BLKWORDS - 1));
        req_idx_c = IB'(waddr_c >> OB);
        req_tag_c = TW'(waddr_c >> (OB + IB));
        rd_addr_c = DAW'(32'(req_idx_c) * BLKWORDS + 32'(req_off_c));
        wr_addr_c = DAW'(32'(miss_idx_q) * BLKWORDS + 32'(cnt_q));
    end

    // Lookup, miss detection and fill-write qualification
    always_comb begin
        hit_c        = (state_q == IDLE) && bus.imemREN && !bus.flush &&
                       valid_q[req_idx_c] && (tag_arr_q[req_idx_c] == req_tag_c);
        start_miss_c = (state_q == IDLE) && bus.imemREN && !bus.flush && !hit_c;
        last_c       = (cnt_q == OBW'(BLKWORDS - 1));
        fill_we_c    = (state_q == FILL) && !bus.iwait && !bus.flush;
    end

    always_comb begin
        bus.ihit     = hit_c;
        bus.imemload = hit_c ? data_arr_q[rd_addr_c] : 32'd0;
        bus.iREN     = (state_q == FILL);
        bus.iaddr    = (state_q == FILL) ?
                       ((32'(miss_tag_q) << (2 + OB + IB)) |
                        (32'(miss_idx_q) << (2 + OB)) |
                        (32'(cnt_q) << 2)) : 32'd0;
    end

    // Control state and valid bits; flush takes priority over completing a fill
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            valid_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end else if (start_miss_c) begin
                        state_q             <= FILL;
                        miss_tag_q          <= req_tag_c;
                        miss_idx_q          <= req_idx_c;
                        cnt_q               <= '0;
                        valid_q[req_idx_c]  <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (!bus.iwait) begin
                        cnt_q <= cnt_q + OBW'(1);
                        if (last_c) begin
                            valid_q[miss_idx_q] <= 1'b1;
                            state_q             <= IDLE;
                            cnt_q               <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits guard them
    always_ff @(posedge CLK) begin
        if (fill_we_c) begin
            data_arr_q[wr_addr_c] <= bus.iload;
            if (last_c) begin
                tag_arr_q[miss_idx_q] <= miss_tag_q;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hitcnt_q;
    logic [31:0] misscnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitcnt_q  <= '0;
            misscnt_q <= '0;
        end else begin
            if (hit_c)        hitcnt_q  <= hitcnt_q + 32'd1;
            if (start_miss_c) misscnt_q <= misscnt_q + 32'd1;
        end
    end

    assign hitcnt  = hitcnt_q;
    assign misscnt = misscnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: randomized fetches against a tag/valid reference model
// and an address-keyed memory model; a monitor pops expected fills and hits.
module tb_icache_dm;

    localparam int unsigned NSETS = 16;
    localparam int unsigned BLK   = 2;
    localparam int unsigned OB    = $clog2(BLK);
    localparam int unsigned IB    = $clog2(NSETS);

    logic CLK;
    logic nRST;
    icache_dm_if bus ();
`ifdef ICACHE_STATS_EN
    logic [31:0] hitcnt;
    logic [31:0] misscnt;
`endif

    icache_dm #(.NSETS(NSETS), .BLKWORDS(BLK), .CPUID(0)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hitcnt  (hitcnt),
        .misscnt (misscnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    bit mon_en = 1'b0;
    int fixed_waits = 0;
    int wait_left = 0;

    logic [31:0] hit_q[$];
    logic [31:0] fill_q[$];
    bit          mvalid [NSETS];
    int unsigned mtag   [NSETS];
    int unsigned mhits = 0;
    int unsigned mmiss = 0;
    logic [31:0] mem_over [logic [31:0]];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int next_waits();
        if (fixed_waits >= 0) return fixed_waits;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(NSETS); i++) mvalid[i] = 1'b0;
    endtask

    // Memory: a programmable number of wait cycles before each word
    always @(posedge CLK) begin
        #1;
        if (bus.iREN) begin
            if (wait_left > 0) begin
                bus.iwait = 1'b1;
                bus.iload = 32'd0;
                wait_left--;
            end else begin
                bus.iwait = 1'b0;
                bus.iload = mem_word(bus.iaddr);
                wait_left = next_waits();
            end
        end else begin
            bus.iwait = 1'b1;
            bus.iload = 32'd0;
            wait_left = next_waits();
        end
    end

    // Monitor: each accepted memory word and each hit consumes one expected entry
    always @(negedge CLK) begin
        if (mon_en && nRST) begin
            if (bus.iREN && bus.iwait && fill_q.size() > 0)
                check32("iaddr_hold", bus.iaddr, fill_q[0]);
            if (bus.iREN && !bus.iwait) begin
                if (fill_q.size() == 0) check32("unexpected_fill", bus.iaddr, 32'hFFFF_FFFF);
                else check32("fill_iaddr", bus.iaddr, fill_q.pop_front());
            end
            if (bus.ihit) begin
                if (hit_q.size() == 0) check32("unexpected_hit", bus.imemload, 32'hFFFF_FFFF);
                else check32("hit_data", bus.imemload, hit_q.pop_front());
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        int unsigned idx = (a >> (2 + OB)) % NSETS;
        int unsigned tg  = a >> (2 + OB + IB);
        bit hit = mvalid[idx] && (mtag[idx] == tg);
        int n = 0;
        int exp_lat;
        @(posedge CLK); #1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        if (!hit) begin
            for (int w = 0; w < int'(BLK); w++)
                fill_q.push_back((a & ~32'(BLK * 4 - 1)) + 32'(w * 4));
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            mmiss++;
        end
        mhits++;
        hit_q.push_back(mem_word(a));
        exp_lat = hit ? 0 : ((fixed_waits < 0) ? -1 : int'(BLK) * (fixed_waits + 1) + 1);
        forever begin
            @(negedge CLK);
            if (bus.ihit) break;
            n++;
            if (n > 200) begin
                check32("fetch_timeout", 32'(n), 32'(exp_lat));
                break;
            end
        end
        if (exp_lat >= 0 && n <= 200) check32("latency", 32'(n), 32'(exp_lat));
        @(posedge CLK); #1;
        bus.imemREN = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge CLK); #1;
        bus.flush = 1'b1;
        model_clear();
        @(posedge CLK); #1;
        bus.flush = 1'b0;
    endtask

`ifdef ICACHE_STATS_EN
    task automatic check_stats(input string tag);
        @(negedge CLK);
        check32({tag, "_hitcnt"}, hitcnt, 32'(mhits));
        check32({tag, "_misscnt"}, misscnt, 32'(mmiss));
    endtask
`endif

    initial begin
        nRST = 1'b0;
        bus.imemREN = 1'b0; bus.imemaddr = 32'd0; bus.flush = 1'b0;
        bus.iwait = 1'b1; bus.iload = 32'd0;
        mem_over[32'h40] = 32'hAAAA_0001;
        mem_over[32'h44] = 32'hAAAA_0002;
        model_clear();
        repeat (2) @(negedge CLK);
        check32("rst_ihit", 32'(bus.ihit), 32'd0);
        check32("rst_imemload", bus.imemload, 32'd0);
        check32("rst_iREN", 32'(bus.iREN), 32'd0);
        check32("rst_iaddr", bus.iaddr, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        mon_en = 1'b1;

        // Cold miss, then hits within the same line
        fixed_waits = 0;
        fetch(32'h40);
        fetch(32'h44);
        fetch(32'h40);
        fetch(32'h44);
`ifdef ICACHE_STATS_EN
        check_stats("cold");
`endif
        // Conflict on index 8 evicts, then original line misses again
        fetch(32'hC0);
        fetch(32'h40);
        // Three wait cycles per word
        fixed_waits = 3;
        fetch(32'h104);
        fixed_waits = 0;
        fetch(32'h40);
        do_flush();
        fetch(32'h40);

        // Flush while the second word is being returned
        mon_en = 1'b0;
        do_flush();
        @(posedge CLK); #1;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        mmiss++;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus.flush = 1'b1;
        @(negedge CLK);
        check32("flushfill_iREN", 32'(bus.iREN), 32'd1);
        check32("flushfill_iaddr", bus.iaddr, 32'h44);
        @(posedge CLK); #1;
        bus.flush = 1'b0; bus.imemREN = 1'b0;
        @(negedge CLK);
        check32("flushfill_iREN_after", 32'(bus.iREN), 32'd0);
        check32("flushfill_ihit_after", 32'(bus.ihit), 32'd0);
        model_clear();
        mon_en = 1'b1;
        fetch(32'h40);

        // Reset while word 1 is outstanding
        mon_en = 1'b0;
        @(posedge CLK); #1;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h84;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check32("midfill_iaddr", bus.iaddr, 32'h84);
        #1 nRST = 1'b0;
        #1;
        check32("midrst_ihit", 32'(bus.ihit), 32'd0);
        check32("midrst_imemload", bus.imemload, 32'd0);
        check32("midrst_iREN", 32'(bus.iREN), 32'd0);
        check32("midrst_iaddr", bus.iaddr, 32'd0);
        @(posedge CLK); #1;
        bus.imemREN = 1'b0;
        nRST = 1'b1;
        model_clear();
        mhits = 0; mmiss = 0;
        mon_en = 1'b1;
        fetch(32'h84);
        fetch(32'h80);
`ifdef ICACHE_STATS_EN
        check_stats("post_rst");
`endif

        // Random traffic with random wait states and occasional flushes
        fixed_waits = -1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 3), 7'd0} | 32'($urandom_range(0, 127) & 32'h7C);
            if ($urandom_range(0, 29) == 0) do_flush();
            fetch(a);
        end
        repeat (3) @(negedge CLK);
        check32("hitq_drained", 32'(hit_q.size()), 32'd0);
        check32("fillq_drained", 32'(fill_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
        check_stats("final");
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d checks expected completion", checks);
        $fatal(1);
    end

endmodule
